count_seq_monitor: RTL and testbench

- Sits directly downstream of the 3-bit binary sequence counter and consumes its count output.
- Checks that the count advances by +1 mod 2^WIDTH every enabled cycle and treats an unexpected return to 0 as an upstream restart.
- Produces registered one-hot phase strobes, a wrap pulse, a full-cycle counter and fault indications for the control logic that follows.

---
 rtl/count_seq_monitor.sv | 176 +++++++++++++++++
 tb/tb_count_seq_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
// Watches the count output of an upstream WIDTH-bit binary counter and checks
// that it advances by one (modulo 2**WIDTH) on every enabled cycle and holds
// otherwise. A return to 0 while locked is an upstream restart, not a fault.
// Every output is registered: a count_in sampled at an edge shows up in the
// outputs just after that same edge.
//
// Optional feature: define SEQ_MON_ERRCNT_EN to add the saturating err_cnt
// output (ERR_W bits). When the macro is undefined the port and its logic are
// absent and everything else behaves the same.
module count_seq_monitor #(
  parameter int WIDTH = 3,
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clr_fault,
  output logic [2**WIDTH-1:0]   phase,
  output logic                  wrap,
  output logic                  restart,
  output logic [CYC_W-1:0]      cycles,
  output logic                  locked,
  output logic                  err,
  output logic                  fault_sticky
`ifdef SEQ_MON_ERRCNT_EN
  ,
  output logic [ERR_W-1:0]      err_cnt
`endif
);

  localparam int PW = 2**WIDTH;
  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // One-hot decode of a count value into the phase strobe vector.
  function automatic logic [PW-1:0] onehot(input logic [WIDTH-1:0] idx);
    logic [PW-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Saturating increment for the error counter; sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [WIDTH-1:0] w_exp;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_nxt;
  logic             r_wrap;
  logic             w_wrap;
  logic             r_restart;
  logic             w_restart;
  logic             r_err;
  logic             w_err;
  logic             r_sticky;
  logic             w_sticky_nxt;
  logic [CYC_W-1:0] r_cycles;
  logic [CYC_W-1:0] w_cycles_nxt;

  // Next-state and next-output decision for the sequence checker.
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_phase_nxt  = '0;
    w_wrap       = 1'b0;
    w_restart    = 1'b0;
    w_err        = 1'b0;
    w_cycles_nxt = r_cycles;
    w_exp        = en ? (r_prev + WIDTH'(1)) : r_prev;

    case (r_state)
      // SYNC and FAULT both wait for a 0 to (re)acquire the sequence; en is
      // irrelevant here and nothing is flagged while waiting.
      SYNC, FAULT: begin
        if (count_in == '0) begin
          w_state_nxt = LOCKED;
          w_prev_nxt  = '0;
          w_phase_nxt = onehot('0);
        end
      end
      LOCKED: begin
        if (count_in == w_exp) begin
          w_prev_nxt  = count_in;
          w_phase_nxt = onehot(count_in);
          if (en && (r_prev == MAX_CNT) && (count_in == '0)) begin
            w_wrap       = 1'b1;
            w_cycles_nxt = r_cycles + CYC_W'(1);
          end
        end else if (count_in == '0) begin
          // Unexpected 0: upstream counter was restarted, follow it silently.
          w_restart   = 1'b1;
          w_prev_nxt  = '0;
          w_phase_nxt = onehot('0);
        end else begin
          w_err       = 1'b1;
          w_state_nxt = FAULT;
        end
      end
      default: begin
        w_state_nxt = SYNC;
      end
    endcase

    // A new error outranks a simultaneous clear.
    if (w_err) begin
      w_sticky_nxt = 1'b1;
    end else if (clr_fault) begin
      w_sticky_nxt = 1'b0;
    end else begin
      w_sticky_nxt = r_sticky;
    end
  end

  // State, tracked count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SYNC;
      r_prev    <= '0;
      r_phase   <= '0;
      r_wrap    <= 1'b0;
      r_restart <= 1'b0;
      r_err     <= 1'b0;
      r_sticky  <= 1'b0;
      r_cycles  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_prev_nxt;
      r_phase   <= w_phase_nxt;
      r_wrap    <= w_wrap;
      r_restart <= w_restart;
      r_err     <= w_err;
      r_sticky  <= w_sticky_nxt;
      r_cycles  <= w_cycles_nxt;
    end
  end

  assign phase        = r_phase;
  assign wrap         = r_wrap;
  assign restart      = r_restart;
  assign cycles       = r_cycles;
  assign locked       = (r_state == LOCKED);
  assign err          = r_err;
  assign fault_sticky = r_sticky;

`ifdef SEQ_MON_ERRCNT_EN
  logic [ERR_W-1:0] r_err_cnt;

  // Saturating error tally; a clear that coincides with an error leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr_fault) begin
      r_err_cnt <= w_err ? ERR_W'(1) : '0;
    end else if (w_err) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Testbench for count_seq_monitor. Built with CYC_W=4 so cycle-count rollover
// is reachable quickly, and ERR_W=2 so err_cnt saturation is reachable when
// SEQ_MON_ERRCNT_EN is defined.
module tb_count_seq_monitor;

  localparam int WIDTH = 3;
  localparam int CYC_W = 4;
  localparam int ERR_W = 2;
  localparam int PW    = 2**WIDTH;

  typedef logic [PW+CYC_W+5-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] count_in;
  logic             clr_fault;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             restart;
  logic [CYC_W-1:0] cycles;
  logic             locked;
  logic             err;
  logic             fault_sticky;
`ifdef SEQ_MON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] ecnt_q[$];
`endif

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];
  logic [CYC_W-1:0] m_cyc;

  always #5 clk = ~clk;

  count_seq_monitor #(
    .WIDTH(WIDTH),
    .CYC_W(CYC_W),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .count_in(count_in),
    .clr_fault(clr_fault),
    .phase(phase),
    .wrap(wrap),
    .restart(restart),
    .cycles(cycles),
    .locked(locked),
    .err(err),
    .fault_sticky(fault_sticky)
`ifdef SEQ_MON_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  function automatic vec_t mk(input logic [PW-1:0] ph, input logic wr, input logic rs,
                              input logic [CYC_W-1:0] cy, input logic lk, input logic er,
                              input logic st);
    return {ph, wr, rs, cy, lk, er, st};
  endfunction

  function automatic vec_t obs();
    return {phase, wrap, restart, cycles, locked, err, fault_sticky};
  endfunction

  function automatic logic [PW-1:0] oh(input int v);
    logic [PW-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  // Apply one cycle of inputs, then settle just past the rising edge.
  task automatic cyc(input logic r, input logic e, input logic [WIDTH-1:0] c, input logic cl);
    rst = r; en = e; count_in = c; clr_fault = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t ev;
    exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0));
`ifdef SEQ_MON_ERRCNT_EN
    ecnt_q.push_back('0);
`endif
    cyc(1, 1, 3'd0, 1);
    ev = exp_q.pop_front();
    total++;
    if (obs() !== ev) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs(), ev);
    end
`ifdef SEQ_MON_ERRCNT_EN
    total++;
    if (err_cnt !== ecnt_q[0]) begin
      bad++;
      $display("FAIL reset_errcnt: got %0d want %0d", err_cnt, ecnt_q[0]);
    end
    void'(ecnt_q.pop_front());
`endif
    // Nonzero count in SYNC: stay unlocked, nothing flagged.
    exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0));
    cyc(0, 1, 3'd5, 0);
    ev = exp_q.pop_front();
    total++;
    if (obs() !== ev) begin
      bad++;
      $display("FAIL sync_hold: got %h want %h", obs(), ev);
    end
    m_cyc = '0;
  endtask

  task automatic test_count_sequence();
    vec_t ev;
    logic wr;
    for (int i = 0; i < 10; i++) begin
      wr = (i == 8);
      if (wr) m_cyc = m_cyc + 1'b1;
      exp_q.push_back(mk(oh(i % 8), wr, 0, m_cyc, 1, 0, 0));
      cyc(0, 1, WIDTH'(i % 8), 0);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL count_seq step %0d: got %h want %h", i, obs(), ev);
      end
    end
  endtask

  task automatic test_hold();
    vec_t ev;
    logic       t_en [6] = '{1, 1, 0, 0, 0, 1};
    logic [2:0] t_cnt[6] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [7:0] t_ph [6] = '{8'h04, 8'h08, 8'h08, 8'h08, 8'h08, 8'h10};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk(t_ph[i], 0, 0, m_cyc, 1, 0, 0));
      cyc(0, t_en[i], t_cnt[i], 0);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL hold step %0d: got %h want %h", i, obs(), ev);
      end
    end
  endtask

  task automatic test_restart();
    vec_t ev;
    logic [2:0] t_cnt[3] = '{3'd5, 3'd0, 3'd1};
    logic [7:0] t_ph [3] = '{8'h20, 8'h01, 8'h02};
    logic       t_rs [3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(t_ph[i], 0, t_rs[i], m_cyc, 1, 0, 0));
      cyc(0, 1, t_cnt[i], 0);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL restart step %0d: got %h want %h", i, obs(), ev);
      end
    end
  endtask

  task automatic test_fault();
    vec_t ev;
    logic       t_en [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic [2:0] t_cnt[8] = '{3'd2, 3'd6, 3'd3, 3'd0, 3'd1, 3'd2, 3'd5, 3'd0};
    logic       t_clr[8] = '{0, 0, 0, 0, 1, 0, 1, 1};
    logic [7:0] t_ph [8] = '{8'h04, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h01};
    logic       t_lk [8] = '{1, 0, 0, 1, 1, 1, 0, 1};
    logic       t_er [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    logic       t_st [8] = '{0, 1, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(t_ph[i], 0, 0, m_cyc, t_lk[i], t_er[i], t_st[i]));
      cyc(0, t_en[i], t_cnt[i], t_clr[i]);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL fault step %0d: got %h want %h", i, obs(), ev);
      end
    end
  endtask

  task automatic test_wraps();
    vec_t ev;
    int c;
    logic wr;
    // Starts locked at count 0; sixteen full laps roll cycles through 15->0.
    for (int lap = 0; lap < 16; lap++) begin
      for (int k = 1; k <= 8; k++) begin
        c  = k % 8;
        wr = (c == 0);
        if (wr) m_cyc = m_cyc + 1'b1;
        exp_q.push_back(mk(oh(c), wr, 0, m_cyc, 1, 0, 0));
        cyc(0, 1, WIDTH'(c), 0);
        ev = exp_q.pop_front();
        total++;
        if (obs() !== ev) begin
          bad++;
          $display("FAIL wraps lap %0d cnt %0d: got %h want %h", lap, c, obs(), ev);
        end
      end
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(oh(k), 0, 0, m_cyc, 1, 0, 0));
      cyc(0, 1, WIDTH'(k), 0);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL prerst cnt %0d: got %h want %h", k, obs(), ev);
      end
    end
    m_cyc = '0;
    exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0));
    cyc(1, 1, 3'd5, 0);
    ev = exp_q.pop_front();
    total++;
    if (obs() !== ev) begin
      bad++;
      $display("FAIL midrst: got %h want %h", obs(), ev);
    end
    // Back in SYNC: a nonzero count neither locks nor errors.
    exp_q.push_back(mk('0, 0, 0, '0, 0, 0, 0));
    cyc(0, 1, 3'd3, 0);
    ev = exp_q.pop_front();
    total++;
    if (obs() !== ev) begin
      bad++;
      $display("FAIL postrst_sync: got %h want %h", obs(), ev);
    end
  endtask

`ifdef SEQ_MON_ERRCNT_EN
  task automatic test_errcnt();
    vec_t ev;
    logic st;
    logic [ERR_W-1:0] ecur;
    logic [ERR_W-1:0] t_ec[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
    st   = 1'b0;
    ecur = '0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(mk(8'h01, 0, 0, m_cyc, 1, 0, st));
      ecnt_q.push_back(ecur);
      cyc(0, 1, 3'd0, 0);
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL errcnt_lock %0d: got %h want %h", k, obs(), ev);
      end
      total++;
      if (err_cnt !== ecnt_q[0]) begin
        bad++;
        $display("FAIL errcnt_hold %0d: got %0d want %0d", k, err_cnt, ecnt_q[0]);
      end
      void'(ecnt_q.pop_front());
      st   = 1'b1;
      ecur = t_ec[k];
      exp_q.push_back(mk(8'h00, 0, 0, m_cyc, 0, 1, 1));
      ecnt_q.push_back(ecur);
      cyc(0, 1, 3'd3, (k == 5));
      ev = exp_q.pop_front();
      total++;
      if (obs() !== ev) begin
        bad++;
        $display("FAIL errcnt_err %0d: got %h want %h", k, obs(), ev);
      end
      total++;
      if (err_cnt !== ecnt_q[0]) begin
        bad++;
        $display("FAIL errcnt_val %0d: got %0d want %0d", k, err_cnt, ecnt_q[0]);
      end
      void'(ecnt_q.pop_front());
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; count_in = '0; clr_fault = 1'b0;
    m_cyc = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_count_sequence();
    test_hold();
    test_restart();
    test_fault();
    test_wraps();
`ifdef SEQ_MON_ERRCNT_EN
    test_errcnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
